axis_eth_rx_mac_filter: RTL and testbench

// - Destination-MAC frame filter on the management RX path.
// - Sits between the RX AXIS_CDC output (management clock) and APB_AXIS_EthernetRxBuffer.
// - Drops frames not addressed to this node, and runt frames, before they consume RX buffer space.
// - 32-bit AXI-Stream in and out; byte 0 on the wire is tdata[7:0] of beat 0.

---
 rtl/axis_eth_rx_mac_filter.sv | 209 ++++++++++++++++++++
 tb/tb_axis_eth_rx_mac_filter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_eth_rx_mac_filter.sv
// ============================================================================
// Module      : axis_eth_rx_mac_filter
// Description : Destination-MAC / runt frame filter on a 32-bit AXI-Stream RX
//               path. Optional frame counters enabled by ETH_RX_FILTER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_eth_rx_mac_filter (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [31:0] s_tdata,
    input  logic [3:0]  s_tkeep,
    input  logic        s_tlast,
    input  logic        s_tuser,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tuser,
    input  logic [47:0] our_mac,
    input  logic        promisc,
    input  logic        allow_mcast,
    input  logic        stats_clear,
    output logic [31:0] cnt_accept,
    output logic [31:0] cnt_drop_addr,
    output logic [31:0] cnt_drop_runt
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR1 = 3'd1,
        ST_FWD0 = 3'd2,
        ST_FWD1 = 3'd3,
        ST_PASS = 3'd4,
        ST_DROP = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_run;
    logic [31:0] r_hdr0;
    logic [31:0] r_hdr1;
    logic [3:0]  r_hdr1_keep;
    logic        r_hdr1_last;
    logic        r_hdr1_user;

    logic        w_cap0;
    logic        w_cap1;
    logic        w_inc_accept;
    logic        w_inc_addr;
    logic        w_inc_runt;
    logic [47:0] w_dst;
    logic        w_accept;

    // Destination spans all of beat 0 and the low two bytes of the live beat 1
    assign w_dst    = {r_hdr0[7:0], r_hdr0[15:8], r_hdr0[23:16], r_hdr0[31:24],
                       s_tdata[7:0], s_tdata[15:8]};
    assign w_accept = promisc | (w_dst == our_mac) | (&w_dst) | (allow_mcast & w_dst[40]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_run       <= 1'b0;
            r_hdr0      <= '0;
            r_hdr1      <= '0;
            r_hdr1_keep <= '0;
            r_hdr1_last <= 1'b0;
            r_hdr1_user <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            if (w_cap0) begin
                r_hdr0 <= s_tdata;
            end
            if (w_cap1) begin
                r_hdr1      <= s_tdata;
                r_hdr1_keep <= s_tkeep;
                r_hdr1_last <= s_tlast;
                r_hdr1_user <= s_tuser;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        s_tready     = 1'b0;
        m_tvalid     = 1'b0;
        m_tdata      = '0;
        m_tkeep      = '0;
        m_tlast      = 1'b0;
        m_tuser      = 1'b0;
        w_cap0       = 1'b0;
        w_cap1       = 1'b0;
        w_inc_accept = 1'b0;
        w_inc_addr   = 1'b0;
        w_inc_runt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_run keeps s_tready low through the reset cycle
                s_tready = r_run;
                if (s_tvalid && r_run) begin
                    if (s_tlast || (s_tkeep != 4'hf)) begin
                        w_inc_runt = 1'b1;
                    end else begin
                        w_cap0 = 1'b1;
                        w_next = ST_HDR1;
                    end
                end
            end
            ST_HDR1: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    w_cap1 = 1'b1;
                    if (s_tlast && (s_tkeep[1:0] != 2'b11)) begin
                        w_inc_runt = 1'b1;
                        w_next     = ST_IDLE;
                    end else if (w_accept) begin
                        w_inc_accept = 1'b1;
                        w_next       = ST_FWD0;
                    end else begin
                        w_inc_addr = 1'b1;
                        w_next     = s_tlast ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_FWD0: begin
                m_tvalid = 1'b1;
                m_tdata  = r_hdr0;
                m_tkeep  = 4'hf;
                if (m_tready) begin
                    w_next = ST_FWD1;
                end
            end
            ST_FWD1: begin
                m_tvalid = 1'b1;
                m_tdata  = r_hdr1;
                m_tkeep  = r_hdr1_keep;
                m_tlast  = r_hdr1_last;
                m_tuser  = r_hdr1_user;
                if (m_tready) begin
                    w_next = r_hdr1_last ? ST_IDLE : ST_PASS;
                end
            end
            ST_PASS: begin
                s_tready = m_tready;
                m_tvalid = s_tvalid;
                m_tdata  = s_tdata;
                m_tkeep  = s_tkeep;
                m_tlast  = s_tlast;
                m_tuser  = s_tuser;
                if (s_tvalid && m_tready && s_tlast) begin
                    w_next = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

`ifdef ETH_RX_FILTER_STATS_EN
    logic [31:0] r_cnt_accept;
    logic [31:0] r_cnt_addr;
    logic [31:0] r_cnt_runt;

    // Saturating counters; a clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || stats_clear) begin
            r_cnt_accept <= '0;
            r_cnt_addr   <= '0;
            r_cnt_runt   <= '0;
        end else begin
            if (w_inc_accept && (r_cnt_accept != 32'hFFFF_FFFF)) begin
                r_cnt_accept <= r_cnt_accept + 32'd1;
            end
            if (w_inc_addr && (r_cnt_addr != 32'hFFFF_FFFF)) begin
                r_cnt_addr <= r_cnt_addr + 32'd1;
            end
            if (w_inc_runt && (r_cnt_runt != 32'hFFFF_FFFF)) begin
                r_cnt_runt <= r_cnt_runt + 32'd1;
            end
        end
    end

    assign cnt_accept    = r_cnt_accept;
    assign cnt_drop_addr = r_cnt_addr;
    assign cnt_drop_runt = r_cnt_runt;
`else
    logic w_unused_stats;

    assign w_unused_stats = ^{stats_clear, w_inc_accept, w_inc_addr, w_inc_runt};
    assign cnt_accept     = '0;
    assign cnt_drop_addr  = '0;
    assign cnt_drop_runt  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_eth_rx_mac_filter.sv
// ============================================================================
// Module      : tb_axis_eth_rx_mac_filter
// Description : Directed self-checking bench for axis_eth_rx_mac_filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_eth_rx_mac_filter;

`ifdef ETH_RX_FILTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tuser;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tuser;
    logic [47:0] our_mac;
    logic        promisc;
    logic        allow_mcast;
    logic        stats_clear;
    logic [31:0] cnt_accept;
    logic [31:0] cnt_drop_addr;
    logic [31:0] cnt_drop_runt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = -1;
    int first_valid_cyc = -1;
    int valid_cycles = 0;
    int stall_seen = 0;
    bit rdy_toggle = 1'b0;

    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];
    int         exp_eof[$];
    bit         exp_user[$];
    logic [7:0] rx_q[$];
    int         rx_eof[$];
    bit         rx_user[$];

    logic        prev_stall = 1'b0;
    logic [38:0] prev_bus = '0;

    axis_eth_rx_mac_filter dut (
        .clk           (clk),
        .rst           (rst),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_tdata       (s_tdata),
        .s_tkeep       (s_tkeep),
        .s_tlast       (s_tlast),
        .s_tuser       (s_tuser),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tdata       (m_tdata),
        .m_tkeep       (m_tkeep),
        .m_tlast       (m_tlast),
        .m_tuser       (m_tuser),
        .our_mac       (our_mac),
        .promisc       (promisc),
        .allow_mcast   (allow_mcast),
        .stats_clear   (stats_clear),
        .cnt_accept    (cnt_accept),
        .cnt_drop_addr (cnt_drop_addr),
        .cnt_drop_runt (cnt_drop_runt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rdy_toggle ? ~m_tready : 1'b1;
        end
    end

    // Output monitor: collects handshaken bytes and checks stall stability
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            for (int k = 0; k < 4; k++) begin
                if (m_tkeep[k]) rx_q.push_back(m_tdata[8*k +: 8]);
            end
            if (m_tlast) begin
                rx_eof.push_back(rx_q.size());
                rx_user.push_back(m_tuser);
            end
        end
        if (m_tvalid) begin
            valid_cycles = valid_cycles + 1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (prev_stall && !rst) begin
            checks = checks + 1;
            stall_seen = stall_seen + 1;
            if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser} !== prev_bus) begin
                errors = errors + 1;
                $display("FAIL stall_hold: got %h required %h", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, prev_bus);
            end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_bus   = {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser};
    end

    function automatic int rx_diff();
        int d = 0;
        if (rx_q.size() != exp_q.size()) d++;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) d++;
        end
        if (rx_eof.size() != exp_eof.size()) d++;
        for (int i = 0; i < rx_eof.size() && i < exp_eof.size(); i++) begin
            if (rx_eof[i] != exp_eof[i]) d++;
        end
        if (rx_user.size() != exp_user.size()) d++;
        for (int i = 0; i < rx_user.size() && i < exp_user.size(); i++) begin
            if (rx_user[i] != exp_user[i]) d++;
        end
        return d;
    endfunction

    task automatic clear_scoreboard();
        exp_q.delete();
        exp_eof.delete();
        exp_user.delete();
        rx_q.delete();
        rx_eof.delete();
        rx_user.delete();
    endtask

    task automatic build_frame(input logic [47:0] dst, input int len, input logic [7:0] seed);
        logic [47:0] src;
        src = 48'h02_00_00_00_00_01;
        frame_q.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6)       frame_q.push_back(dst[47-8*i -: 8]);
            else if (i < 12) frame_q.push_back(src[47-8*(i-6) -: 8]);
            else if (i == 12) frame_q.push_back(8'h08);
            else if (i == 13) frame_q.push_back(8'h00);
            else             frame_q.push_back(seed + 8'(i));
        end
    endtask

    task automatic expect_frame(input bit user);
        foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
        exp_eof.push_back(exp_q.size());
        exp_user.push_back(user);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic u, input bit mark, input bit clr);
        bit hs;
        int waited;
        s_tvalid    = 1'b1;
        s_tdata     = d;
        s_tkeep     = k;
        s_tlast     = l;
        s_tuser     = u;
        stats_clear = clr;
        waited      = 0;
        forever begin
            @(negedge clk);
            hs = s_tready;
            if (hs && mark) hs_cyc = cyc;
            @(posedge clk);
            #1;
            if (hs) break;
            waited++;
            if (waited > 2000) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL send_timeout: s_tready stuck low, waited %0d required <2000 cycles", waited);
                break;
            end
        end
        s_tvalid    = 1'b0;
        stats_clear = 1'b0;
    endtask

    task automatic send_frame(input bit user, input int gap_max, input int max_beats, input bit clr_b1);
        int nb;
        logic [31:0] d;
        logic [3:0]  k;
        nb = (frame_q.size() + 3) / 4;
        for (int b = 0; b < nb && b < max_beats; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 4; j++) begin
                if (4*b + j < frame_q.size()) begin
                    d[8*j +: 8] = frame_q[4*b + j];
                    k[j] = 1'b1;
                end
            end
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_beat(d, k, b == nb - 1, user && (b == nb - 1), b == 1, clr_b1 && (b == 1));
        end
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks = checks + 7;
        if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b required 0", s_tready); end
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b required 0", m_tvalid); end
        if (m_tlast !== 1'b0 || m_tuser !== 1'b0) begin errors++; $display("FAIL rst_last_user: got %b%b required 00", m_tlast, m_tuser); end
        if (m_tdata !== 32'h0 || m_tkeep !== 4'h0) begin errors++; $display("FAIL rst_data_keep: got %h/%h required 0/0", m_tdata, m_tkeep); end
        if (cnt_accept !== 32'd0) begin errors++; $display("FAIL rst_cnt_accept: got %0d required 0", cnt_accept); end
        if (cnt_drop_addr !== 32'd0) begin errors++; $display("FAIL rst_cnt_addr: got %0d required 0", cnt_drop_addr); end
        if (cnt_drop_runt !== 32'd0) begin errors++; $display("FAIL rst_cnt_runt: got %0d required 0", cnt_drop_runt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain(3);
    endtask

    task automatic test_unicast();
        int d;
        clear_scoreboard();
        first_valid_cyc = -1;
        build_frame(48'h02_00_00_12_34_56, 64, 8'h10);
        expect_frame(1'b0);
        send_frame(1'b0, 0, 1000, 1'b0);
        drain(10);
        d = rx_diff();
        checks = checks + 4;
        if (rx_q.size() !== 64) begin errors++; $display("FAIL uni_len: got %0d required 64", rx_q.size()); end
        if (d !== 0) begin errors++; $display("FAIL uni_data: got %0d diffs required 0", d); end
        if (first_valid_cyc !== hs_cyc + 1) begin errors++; $display("FAIL uni_latency: got cycle %0d required %0d", first_valid_cyc, hs_cyc + 1); end
        if (cnt_accept !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL uni_cnt_accept: got %0d required %0d", cnt_accept, STATS ? 1 : 0); end
    endtask

    task automatic test_bcast_mcast();
        int d;
        int vc;
        clear_scoreboard();
        build_frame(48'hFF_FF_FF_FF_FF_FF, 60, 8'h20);
        expect_frame(1'b0);
        send_frame(1'b0, 0, 1000, 1'b0);
        drain(10);
        vc = valid_cycles;
        build_frame(48'h01_00_5E_00_00_01, 64, 8'h30);
        send_frame(1'b0, 0, 1000, 1'b0);
        drain(10);
        d = rx_diff();
        checks = checks + 3;
        if (d !== 0) begin errors++; $display("FAIL bcast_data: got %0d diffs required 0", d); end
        if (valid_cycles !== vc) begin errors++; $display("FAIL mcast_blocked: got %0d valid cycles required 0", valid_cycles - vc); end
        if (cnt_drop_addr !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL mcast_cnt_addr: got %0d required %0d", cnt_drop_addr, STATS ? 1 : 0); end
    endtask

    task automatic test_mcast_promisc();
        int d;
        clear_scoreboard();
        allow_mcast = 1'b1;
        build_frame(48'h01_00_5E_00_00_01, 64, 8'h30);
        expect_frame(1'b0);
        send_frame(1'b0, 0, 1000, 1'b0);
        allow_mcast = 1'b0;
        promisc = 1'b1;
        build_frame(48'h02_00_00_99_99_99, 64, 8'h40);
        expect_frame(1'b1);
        send_frame(1'b1, 0, 1000, 1'b0);
        promisc = 1'b0;
        drain(10);
        d = rx_diff();
        checks = checks + 2;
        if (d !== 0) begin errors++; $display("FAIL mcast_promisc_data: got %0d diffs required 0", d); end
        if (cnt_accept !== (STATS ? 32'd4 : 32'd0)) begin errors++; $display("FAIL mp_cnt_accept: got %0d required %0d", cnt_accept, STATS ? 4 : 0); end
    endtask

    task automatic test_runt();
        int vc;
        clear_scoreboard();
        vc = valid_cycles;
        build_frame(48'h02_00_00_12_34_56, 4, 8'h50);
        send_frame(1'b0, 0, 1000, 1'b0);
        build_frame(48'h02_00_00_12_34_56, 5, 8'h50);
        send_frame(1'b0, 0, 1000, 1'b0);
        drain(10);
        checks = checks + 2;
        if (valid_cycles !== vc) begin errors++; $display("FAIL runt_blocked: got %0d valid cycles required 0", valid_cycles - vc); end
        if (cnt_drop_runt !== (STATS ? 32'd2 : 32'd0)) begin errors++; $display("FAIL runt_cnt: got %0d required %0d", cnt_drop_runt, STATS ? 2 : 0); end
    endtask

    task automatic test_stall();
        int d;
        clear_scoreboard();
        stall_seen = 0;
        rdy_toggle = 1'b1;
        build_frame(48'h02_00_00_12_34_56, 67, 8'h60);
        expect_frame(1'b0);
        send_frame(1'b0, 3, 1000, 1'b0);
        drain(20);
        rdy_toggle = 1'b0;
        drain(3);
        d = rx_diff();
        checks = checks + 3;
        if (d !== 0) begin errors++; $display("FAIL stall_data: got %0d diffs required 0", d); end
        if (stall_seen == 0) begin errors++; $display("FAIL stall_cover: got %0d stalled cycles required >0", stall_seen); end
        if (cnt_accept !== (STATS ? 32'd5 : 32'd0)) begin errors++; $display("FAIL stall_cnt_accept: got %0d required %0d", cnt_accept, STATS ? 5 : 0); end
    endtask

    task automatic test_back_to_back();
        int d;
        clear_scoreboard();
        build_frame(48'h02_00_00_12_34_56, 8, 8'h70);
        expect_frame(1'b1);
        send_frame(1'b1, 0, 1000, 1'b0);
        build_frame(48'h02_00_00_12_34_56, 6, 8'h71);
        expect_frame(1'b0);
        send_frame(1'b0, 0, 1000, 1'b0);
        build_frame(48'h02_00_00_AB_CD_EF, 8, 8'h72);
        send_frame(1'b0, 0, 1000, 1'b0);
        build_frame(48'h02_00_00_AB_CD_EF, 20, 8'h73);
        send_frame(1'b0, 0, 1000, 1'b0);
        build_frame(48'h02_00_00_12_34_56, 64, 8'h74);
        expect_frame(1'b1);
        send_frame(1'b1, 0, 1000, 1'b0);
        drain(10);
        d = rx_diff();
        checks = checks + 4;
        if (d !== 0) begin errors++; $display("FAIL b2b_data: got %0d diffs required 0", d); end
        if (rx_eof.size() !== 3) begin errors++; $display("FAIL b2b_frames: got %0d required 3", rx_eof.size()); end
        if (cnt_accept !== (STATS ? 32'd8 : 32'd0)) begin errors++; $display("FAIL b2b_cnt_accept: got %0d required %0d", cnt_accept, STATS ? 8 : 0); end
        if (cnt_drop_addr !== (STATS ? 32'd3 : 32'd0)) begin errors++; $display("FAIL b2b_cnt_addr: got %0d required %0d", cnt_drop_addr, STATS ? 3 : 0); end
    endtask

    task automatic test_reset_mid();
        int d;
        build_frame(48'h02_00_00_12_34_56, 64, 8'h80);
        send_frame(1'b0, 0, 6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks = checks + 4;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin errors++; $display("FAIL rstmid_hs: got valid=%b ready=%b required 0/0", m_tvalid, s_tready); end
        if (m_tlast !== 1'b0 || m_tuser !== 1'b0) begin errors++; $display("FAIL rstmid_last_user: got %b%b required 00", m_tlast, m_tuser); end
        if (m_tdata !== 32'h0 || m_tkeep !== 4'h0) begin errors++; $display("FAIL rstmid_data: got %h/%h required 0/0", m_tdata, m_tkeep); end
        if (cnt_accept !== 32'd0 || cnt_drop_addr !== 32'd0 || cnt_drop_runt !== 32'd0) begin
            errors++; $display("FAIL rstmid_cnt: got %0d/%0d/%0d required 0/0/0", cnt_accept, cnt_drop_addr, cnt_drop_runt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain(3);
        clear_scoreboard();
        build_frame(48'h02_00_00_12_34_56, 64, 8'h90);
        expect_frame(1'b0);
        send_frame(1'b0, 0, 1000, 1'b0);
        drain(10);
        checks = checks + 1;
        if (cnt_accept !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL rstmid_cnt1: got %0d required %0d", cnt_accept, STATS ? 1 : 0); end
        build_frame(48'h02_00_00_12_34_56, 40, 8'hA0);
        expect_frame(1'b0);
        send_frame(1'b0, 0, 1000, 1'b1);
        drain(10);
        d = rx_diff();
        checks = checks + 2;
        if (d !== 0) begin errors++; $display("FAIL rstmid_data_after: got %0d diffs required 0", d); end
        if (cnt_accept !== 32'd0) begin errors++; $display("FAIL clear_vs_accept: got %0d required 0", cnt_accept); end
    endtask

    initial begin
        rst         = 1'b1;
        s_tvalid    = 1'b0;
        s_tdata     = '0;
        s_tkeep     = '0;
        s_tlast     = 1'b0;
        s_tuser     = 1'b0;
        our_mac     = 48'h02_00_00_12_34_56;
        promisc     = 1'b0;
        allow_mcast = 1'b0;
        stats_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_unicast();
        test_bcast_mcast();
        test_mcast_promisc();
        test_runt();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
